// File: rtl/mem_stage_if.sv
// Bundle of the EX/MEM entry, the data-memory port and the MEM/WB results of mem_stage.
// The stage itself connects through the slave modport.
interface mem_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  i_mem_read;
  logic                  i_mem_write;
  logic [1:0]            i_size;
  logic                  i_unsigned;
  logic [DATA_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rt;
  logic [1:0]            i_wb;

  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_WIDTH-1:0] dm_addr;
  logic [3:0]            dm_be;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ready;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  o_stall;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_result;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic [1:0]            o_wb;
  logic                  o_misalign;

  modport slave (
    input  i_valid, i_mem_read, i_mem_write, i_size, i_unsigned, i_addr, i_rt, i_wb,
    input  dm_ready, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output o_stall, o_valid, o_result, o_rdata, o_wb, o_misalign
  );

  modport master (
    output i_valid, i_mem_read, i_mem_write, i_size, i_unsigned, i_addr, i_rt, i_wb,
    output dm_ready, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  o_stall, o_valid, o_result, o_rdata, o_wb, o_misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues aligned loads/stores to data memory, stalls upstream while waiting,
// and hands ALU results, load data or misalignment flags to MEM/WB.
module mem_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_reg;
  logic [1:0]            wb_reg;
  logic [1:0]            lane_reg;
  logic [1:0]            size_reg;
  logic                  uns_reg;
  logic [DATA_WIDTH-1:0] result_reg;

  logic                  mem_op;
  logic                  misalign;
  logic                  accept_mem;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [7:0]            rd_bytes [4];
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    mem_op = bus.i_mem_read | bus.i_mem_write;
    case (bus.i_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.i_addr[0];
      default: misalign = |bus.i_addr[1:0];
    endcase
    accept_mem = (state_reg == IDLE) && bus.i_valid && mem_op && !misalign;
  end

  assign bus.o_stall = (state_reg == BUSY) || accept_mem;

  // Lanes and store data are formed from the live inputs so they can be registered on accept.
  always_comb begin
    case (bus.i_size)
      2'b00: begin
        be_next    = 4'b0001 << bus.i_addr[1:0];
        wdata_next = {(DATA_WIDTH/8){bus.i_rt[7:0]}};
      end
      2'b01: begin
        be_next    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {(DATA_WIDTH/16){bus.i_rt[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = bus.i_rt;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_bytes[gi] = bus.dm_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = rd_bytes[lane_reg];
    half_sel = lane_reg[1] ? {rd_bytes[3], rd_bytes[2]} : {rd_bytes[1], rd_bytes[0]};
    case (size_reg)
      2'b00:   load_data = {{(DATA_WIDTH-8){byte_sel[7] & ~uns_reg}}, byte_sel};
      2'b01:   load_data = {{(DATA_WIDTH-16){half_sel[15] & ~uns_reg}}, half_sel};
      default: load_data = bus.dm_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      wb_reg         <= '0;
      lane_reg       <= '0;
      size_reg       <= '0;
      uns_reg        <= 1'b0;
      result_reg     <= '0;
      bus.dm_req     <= 1'b0;
      bus.dm_we      <= 1'b0;
      bus.dm_addr    <= '0;
      bus.dm_be      <= '0;
      bus.dm_wdata   <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_result   <= '0;
      bus.o_rdata    <= '0;
      bus.o_wb       <= '0;
      bus.o_misalign <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_valid) begin
            if (!mem_op || misalign) begin
              // Non-memory and misaligned entries complete without touching memory.
              bus.o_valid    <= 1'b1;
              bus.o_result   <= bus.i_addr;
              bus.o_rdata    <= '0;
              bus.o_misalign <= mem_op;
              bus.o_wb       <= mem_op ? 2'b00 : bus.i_wb;
            end else begin
              state_reg    <= BUSY;
              bus.dm_req   <= 1'b1;
              bus.dm_we    <= bus.i_mem_write;
              bus.dm_addr  <= {bus.i_addr[DATA_WIDTH-1:2], 2'b00};
              bus.dm_be    <= be_next;
              bus.dm_wdata <= wdata_next;
              wb_reg       <= bus.i_wb;
              result_reg   <= bus.i_addr;
              size_reg     <= bus.i_size;
              uns_reg      <= bus.i_unsigned;
              lane_reg     <= bus.i_addr[1:0];
            end
          end
        end
        BUSY: begin
          if (bus.dm_ready) begin
            state_reg      <= IDLE;
            bus.dm_req     <= 1'b0;
            bus.o_valid    <= 1'b1;
            bus.o_result   <= result_reg;
            bus.o_wb       <= wb_reg;
            bus.o_misalign <= 1'b0;
            bus.o_rdata    <= bus.dm_we ? '0 : load_data;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage_if #(.DATA_WIDTH(32)) bus ();

  mem_stage #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
    int n = size_bytes(sz);
    int first = int'(addr[1:0]) & ~(n - 1);
    logic [3:0] be = '0;
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + n) be[b] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] rt);
    case (size_bytes(sz))
      1:       return {24'h0, rt[7:0]} * 32'h0101_0101;
      2:       return {16'h0, rt[15:0]} * 32'h0001_0001;
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] word);
    int n = size_bytes(sz);
    logic [31:0] mask;
    logic [31:0] val;
    if (n == 4) return word;
    mask = (32'h1 << (8 * n)) - 32'h1;
    val  = (word >> (8 * int'(addr[1:0]))) & mask;
    if (!uns && val[8*n-1]) val = val | ~mask;
    return val;
  endfunction

  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rt, input logic [1:0] wb,
                        input int dly, input logic [31:0] rdata);
    logic        mem;
    logic        mis;
    logic [31:0] exp_rd;
    logic [1:0]  exp_wb;
    mem = rd | wr;
    mis = mem && ((sz == 2'd1 && addr[0]) || (sz >= 2'd2 && addr[1:0] != 2'd0));

    @(negedge clk);
    check_eq("idle_o_valid", bus.o_valid, 1'b0);
    check_eq("idle_dm_req", bus.dm_req, 1'b0);
    bus.i_valid     = 1'b1;
    bus.i_mem_read  = rd;
    bus.i_mem_write = wr;
    bus.i_size      = sz;
    bus.i_unsigned  = uns;
    bus.i_addr      = addr;
    bus.i_rt        = rt;
    bus.i_wb        = wb;
    bus.dm_ready    = 1'b0;
    #1;
    check_eq("stall_at_accept", bus.o_stall, mem && !mis);

    if (mem && !mis) begin
      for (int k = 0; k <= dly; k++) begin
        @(negedge clk);
        check_eq("dm_req", bus.dm_req, 1'b1);
        check_eq("dm_we", bus.dm_we, wr);
        check_eq("dm_addr", bus.dm_addr, addr & 32'hFFFF_FFFC);
        check_eq("dm_be", bus.dm_be, model_be(sz, addr));
        if (wr) check_eq("dm_wdata", bus.dm_wdata, model_wdata(sz, rt));
        check_eq("busy_stall", bus.o_stall, 1'b1);
        check_eq("busy_o_valid", bus.o_valid, 1'b0);
        // Inputs seen while busy must be ignored.
        bus.i_mem_read  = 1'($urandom);
        bus.i_mem_write = 1'($urandom);
        bus.i_size      = 2'($urandom);
        bus.i_unsigned  = 1'($urandom);
        bus.i_addr      = $urandom;
        bus.i_rt        = $urandom;
        bus.i_wb        = 2'($urandom);
        bus.dm_ready    = (k == dly);
        bus.dm_rdata    = (k == dly) ? rdata : $urandom;
      end
      exp_rd = wr ? 32'h0 : model_load(sz, uns, addr, rdata);
      exp_wb = wb;
    end else begin
      exp_rd = 32'h0;
      exp_wb = mis ? 2'b00 : wb;
    end

    @(negedge clk);
    check_eq("o_valid", bus.o_valid, 1'b1);
    check_eq("o_result", bus.o_result, addr);
    check_eq("o_wb", bus.o_wb, exp_wb);
    check_eq("o_rdata", bus.o_rdata, exp_rd);
    check_eq("o_misalign", bus.o_misalign, mis);
    check_eq("done_dm_req", bus.dm_req, 1'b0);
    $display("op rd=%0d wr=%0d sz=%0d uns=%0d addr=%h rt=%h wb=%0d dly=%0d -> result=%h rdata=%h mis=%0d",
             rd, wr, sz, uns, addr, rt, wb, dly, bus.o_result, bus.o_rdata, bus.o_misalign);
    bus.i_valid  = 1'b0;
    bus.dm_ready = 1'($urandom);
    bus.dm_rdata = $urandom;
    #1;
    check_eq("done_stall", bus.o_stall, 1'b0);
  endtask

  initial begin
    clk             = 1'b0;
    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_mem_read  = 1'b0;
    bus.i_mem_write = 1'b0;
    bus.i_size      = 2'b00;
    bus.i_unsigned  = 1'b0;
    bus.i_addr      = '0;
    bus.i_rt        = '0;
    bus.i_wb        = 2'b00;
    bus.dm_ready    = 1'b0;
    bus.dm_rdata    = '0;

    #12;
    check_eq("rst_dm_req", bus.dm_req, 1'b0);
    check_eq("rst_dm_we", bus.dm_we, 1'b0);
    check_eq("rst_dm_be", bus.dm_be, 4'h0);
    check_eq("rst_dm_addr", bus.dm_addr, 32'h0);
    check_eq("rst_dm_wdata", bus.dm_wdata, 32'h0);
    check_eq("rst_o_valid", bus.o_valid, 1'b0);
    check_eq("rst_o_result", bus.o_result, 32'h0);
    check_eq("rst_o_rdata", bus.o_rdata, 32'h0);
    check_eq("rst_o_wb", bus.o_wb, 2'b00);
    check_eq("rst_o_misalign", bus.o_misalign, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 2'b10, 0, 32'h0);
    run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 2'b01, 3, 32'h80AB_CDEF);
    run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_BEEF, 2'b11, 1, 32'h0);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 2'b11, 0, 32'h0);
    run_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 2'b01, 0, 32'h9000_0000);

    // Reset while a load is outstanding: request drops at once and no result appears.
    @(negedge clk);
    bus.i_valid     = 1'b1;
    bus.i_mem_read  = 1'b1;
    bus.i_mem_write = 1'b0;
    bus.i_size      = 2'd2;
    bus.i_addr      = 32'h0000_0400;
    bus.i_wb        = 2'b01;
    bus.dm_ready    = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_dm_req", bus.dm_req, 1'b1);
    bus.i_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_dm_req", bus.dm_req, 1'b0);
    check_eq("async_rst_o_valid", bus.o_valid, 1'b0);
    check_eq("async_rst_dm_addr", bus.dm_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_ABCD, 32'h0, 2'b10, 0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      run_op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
             2'($urandom), int'($urandom_range(0, 4)), $urandom);
    end

    @(negedge clk);
    check_eq("final_o_valid", bus.o_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
